// File: rtl/req_debounce_pkg.sv
// ---------------------------------------------------------------------------
// req_debounce_pkg : shared constants for the request conditioning front end
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package req_debounce_pkg;

  localparam int unsigned DB_CYCLES_10MS = 1000000;
  localparam int unsigned DB_CYCLES_SIM  = 4;
  localparam int unsigned CNT_W_DEFAULT  = 20;
  localparam int unsigned WIDTH_DEFAULT  = 8;
  // IDX_W must equal ceil(log2(WIDTH)) so every channel is addressable by clr_idx.
  localparam int unsigned IDX_W_DEFAULT  = 3;

endpackage

`default_nettype wire

// File: rtl/req_debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell : single-bit synchronizer, debounce counter and rise detector
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_cell
  import req_debounce_pkg::*;
#(
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
  parameter int unsigned DB_CYCLES = DB_CYCLES_10MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic rise_nxt_o
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             arm_q, arm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // The first disagreeing sample only arms the counter; acceptance then needs
  // DB_CYCLES further stable samples, landing DB_CYCLES+2 edges after sampling.
  always_comb begin
    arm_d   = arm_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (s2_q == level_q) begin
      arm_d = 1'b0;
      cnt_d = '0;
    end else if (!arm_q) begin
      arm_d = 1'b1;
    end else if (cnt_q == c_CNT_LAST) begin
      level_d = s2_q;
      arm_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign rise_nxt_o = rise_d;

endmodule

`default_nettype wire

// File: rtl/req_debounce.sv
// ---------------------------------------------------------------------------
// req_debounce : debounced, edge-detected sticky request vector for encoder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module req_debounce
  import req_debounce_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter int unsigned IDX_W     = IDX_W_DEFAULT,
  parameter int unsigned CNT_W     = CNT_W_DEFAULT,
  parameter int unsigned DB_CYCLES = DB_CYCLES_10MS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn,
  input  logic             clr,
  input  logic [IDX_W-1:0] clr_idx,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] x,
  output logic             any
);

  logic [WIDTH-1:0] level_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] set_w;
  logic [WIDTH-1:0] clr_mask_w;
  logic [WIDTH-1:0] x_q, x_d;
  logic             any_q, any_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    debounce_cell #(
      .CNT_W     (CNT_W),
      .DB_CYCLES (DB_CYCLES)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_i      (btn[i]),
      .level_o    (level_w[i]),
      .rise_o     (rise_w[i]),
      .rise_nxt_o (set_w[i])
    );
  end

  // Set wins over clear because set_w is OR-ed in after the mask is applied.
  always_comb begin
    clr_mask_w = '0;
    if (clr && (32'(clr_idx) < WIDTH)) begin
      clr_mask_w = {{(WIDTH-1){1'b0}}, 1'b1} << clr_idx;
    end
    x_d   = (x_q & ~clr_mask_w) | set_w;
    any_d = |x_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      any_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      any_q <= any_d;
    end
  end

  assign level = level_w;
  assign rise  = rise_w;
  assign x     = x_q;
  assign any   = any_q;

endmodule

`default_nettype wire
